// File: rtl/mcycle_muldiv.sv
// mcycle_muldiv: multi-cycle unsigned shift-add multiplier / restoring divider, one iteration per clock
// Ports: CLK, RESET (async, active-high), Start, MCycleOp (0 mul / 1 div), Operand1, Operand2 in;
//        Result1 (product low / quotient), Result2 (product high / remainder), Busy out.
module mcycle_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             Start,
    input  logic             MCycleOp,
    input  logic [WIDTH-1:0] Operand1,
    input  logic [WIDTH-1:0] Operand2,
    output logic [WIDTH-1:0] Result1,
    output logic [WIDTH-1:0] Result2,
    output logic             Busy
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic [1:0] {IDLE, COMP, DONE} state_t;
    state_t           state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, opb_q;
    logic             op_q;
    logic [WIDTH:0]   sum, sh;
    logic [WIDTH-1:0] diff;
    logic             ge, load, step, last;
    assign load = state_q == IDLE && Start;
    assign step = state_q == COMP;
    assign last = step && count_q == CW'(WIDTH - 1);
    // Multiply: {hi,lo} holds {partial product, remaining multiplier bits}; the
    // add keeps its carry in sum[WIDTH] so the right shift never drops it.
    // Divide: {hi,lo} holds {remainder, dividend/quotient bits}; a zero divisor
    // naturally yields an all-ones quotient with the dividend as remainder.
    always_comb begin
        sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opb_q} : '0);
        sh   = {hi_q, lo_q[WIDTH-1]};
        ge   = sh >= {1'b0, opb_q};
        diff = sh[WIDTH-1:0] - opb_q;
        hi_d = state_q == IDLE ? '0 : op_q ? (ge ? diff : sh[WIDTH-1:0]) : sum[WIDTH:1];
        lo_d = state_q == IDLE ? (MCycleOp ? Operand1 : Operand2)
             : op_q ? {lo_q[WIDTH-2:0], ge} : {sum[0], lo_q[WIDTH-1:1]};
        count_d = state_q == IDLE ? '0 : count_q + 1'b1;
    end
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= IDLE;
            count_q <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            opb_q   <= '0;
            op_q    <= 1'b0;
            Result1 <= '0;
            Result2 <= '0;
        end else begin
            state_q <= state_d;
            if (load || step) begin
                count_q <= count_d;
                hi_q    <= hi_d;
                lo_q    <= lo_d;
            end
            if (load) begin
                op_q  <= MCycleOp;
                opb_q <= MCycleOp ? Operand2 : Operand1;
            end
            if (last) begin
                Result1 <= lo_d;
                Result2 <= hi_d;
            end
        end
    end
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = Start ? COMP : IDLE;
            COMP:    state_d = last ? DONE : COMP;
            default: state_d = IDLE;
        endcase
    end
    always_comb begin
        Busy = state_q == IDLE ? Start : state_q == COMP;
    end
endmodule

// File: tb/tb_mcycle_muldiv.sv
// tb_mcycle_muldiv: randomized self-checking bench for mcycle_muldiv against an arithmetic model
module tb_mcycle_muldiv;
    localparam int W = 32;
    logic         CLK = 1'b0;
    logic         RESET = 1'b1;
    logic         Start = 1'b0;
    logic         MCycleOp = 1'b0;
    logic [W-1:0] Operand1 = '0;
    logic [W-1:0] Operand2 = '0;
    logic [W-1:0] Result1, Result2;
    logic         Busy;
    int checks = 0;
    int errors = 0;
    mcycle_muldiv #(.WIDTH(W)) dut (
        .CLK(CLK), .RESET(RESET), .Start(Start), .MCycleOp(MCycleOp),
        .Operand1(Operand1), .Operand2(Operand2),
        .Result1(Result1), .Result2(Result2), .Busy(Busy)
    );
    always #5 CLK = ~CLK;
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask
    // Starts an op at the next falling edge, holds Start (scrambling the operand
    // buses mid-flight), counts busy cycles and checks results in the DONE cycle.
    task automatic do_op(input logic op, input logic [W-1:0] a, input logic [W-1:0] b, input string tag);
        logic [63:0] prod;
        logic [W-1:0] e1, e2;
        int n;
        prod = 64'(a) * 64'(b);
        if (op == 1'b0) begin
            e1 = prod[W-1:0];
            e2 = prod[2*W-1:W];
        end else if (b == 0) begin
            e1 = '1;
            e2 = a;
        end else begin
            e1 = a / b;
            e2 = a % b;
        end
        @(negedge CLK);
        Start = 1'b1;
        MCycleOp = op;
        Operand1 = a;
        Operand2 = b;
        n = 0;
        #1;
        while (Busy && n < 100) begin
            n++;
            @(negedge CLK);
            if (n == 2) begin
                Operand1 = $urandom;
                Operand2 = $urandom;
                MCycleOp = ~op;
            end
            #1;
        end
        check({tag, " busy"}, 64'(n), 64'(W + 1));
        check({tag, " r1"}, 64'(Result1), 64'(e1));
        check({tag, " r2"}, 64'(Result2), 64'(e2));
    endtask
    initial begin
        logic [W-1:0] h1, h2;
        #1;
        check("rst busy", 64'(Busy), 64'd0);
        check("rst r1", 64'(Result1), 64'd0);
        check("rst r2", 64'(Result2), 64'd0);
        #20 RESET = 1'b0;
        do_op(1'b0, 32'd7, 32'd6, "mul7x6");
        do_op(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, "mulmax");
        do_op(1'b1, 32'd100, 32'd7, "div100_7");
        do_op(1'b1, 32'd5, 32'd9, "div5_9");
        do_op(1'b1, 32'h1234, 32'd0, "div0");
        do_op(1'b0, 32'd3, 32'd3, "mul3x3");
        @(negedge CLK);
        Start = 1'b0;
        h1 = Result1;
        h2 = Result2;
        repeat (3) @(negedge CLK);
        check("idle busy", 64'(Busy), 64'd0);
        check("hold r1", 64'(Result1), 64'(h1));
        check("hold r2", 64'(Result2), 64'(h2));
        @(negedge CLK);
        Start = 1'b1;
        MCycleOp = 1'b1;
        Operand1 = 32'd1000;
        Operand2 = 32'd3;
        repeat (11) @(negedge CLK);
        Start = 1'b0;
        RESET = 1'b1;
        #1;
        check("midrst busy", 64'(Busy), 64'd0);
        check("midrst r1", 64'(Result1), 64'd0);
        check("midrst r2", 64'(Result2), 64'd0);
        @(negedge CLK);
        RESET = 1'b0;
        do_op(1'b1, 32'd1000, 32'd3, "postrst");
        for (int i = 0; i < 20; i++) begin
            logic [W-1:0] a, b;
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 3))
                0: b = 0;
                1: b = $urandom_range(1, 15);
                2: a = $urandom_range(0, 255);
                default: ;
            endcase
            do_op(1'($urandom_range(0, 1)), a, b, $sformatf("rnd%0d", i));
        end
        @(negedge CLK);
        Start = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
